// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Counters are held in a 32-bit word; WIDTH (<= 32) bounds the values loaded into them.
package clkdiv_pkg;

    localparam int MAX_W              = 32;
    localparam int CLKDIV_DEFAULT_DIV = 2;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        word_t cnt;
        word_t div;
        word_t nxt;
        logic  pend;
    } chan_st_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Length of the high phase: ceil(d/2).
    function automatic word_t half_up(input word_t d);
        return (d >> 1) + word_t'(d[0]);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, pending-divisor apply, registered tick/clk_out.
// Outputs lag the counter by one clk; a write is only offered to it while no divisor is pending.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 25,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
)(
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_pend
);

    chan_st_t r_st;
    logic     r_tick;
    logic     r_clk_out;

    word_t    w_div_in;
    word_t    w_cnt_nx;
    logic     w_term;
    logic     w_apply;

    assign w_div_in = (i_div == '0) ? word_t'(1) : word_t'(i_div);
    assign w_term   = i_en && (r_st.cnt == r_st.div - word_t'(1));
    assign w_cnt_nx = w_term ? '0 : r_st.cnt + word_t'(1);
    // A frozen channel has no period to finish, so its pending divisor applies at once.
    assign w_apply  = r_st.pend && (w_term || !i_en);

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_st      <= '{cnt: '0, div: word_t'(DEFAULT_DIV), nxt: word_t'(DEFAULT_DIV), pend: 1'b0};
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_tick <= w_term;
            if (w_apply) begin
                r_st.div  <= r_st.nxt;
                r_st.cnt  <= '0;
                r_st.pend <= 1'b0;
                // Running: the new period opens in its high phase. Frozen: park low.
                r_clk_out <= i_en;
            end else if (i_en) begin
                r_st.cnt  <= w_cnt_nx;
                r_clk_out <= (w_cnt_nx < half_up(r_st.div));
            end
            if (i_wr) begin
                r_st.nxt  <= w_div_in;
                r_st.pend <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_pend    = r_st.pend;

endmodule

// File: rtl/clkdiv_multi.sv
// NCH run-time programmable clock dividers behind one valid/ready config port.
// Outputs are registered (1 clk); cfg_ready drops while the addressed channel holds a pending divisor.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int NCH         = 4,
    parameter  int WIDTH       = 25,
    parameter  int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    localparam int CHW         = ch_width(NCH)
)(
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic [NCH-1:0]   i_en,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CHW-1:0]   i_cfg_ch,
    input  logic [WIDTH-1:0] i_cfg_div,
    output logic [NCH-1:0]   o_tick,
    output logic [NCH-1:0]   o_clk_out,
    output logic [NCH-1:0]   o_pend
);

    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_wr;
    logic           w_ready;

    // Indices with no channel behind them stay ready, so such writes drain harmlessly.
    always_comb begin
        w_sel   = '0;
        w_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (i_cfg_ch == CHW'(i)) begin
                w_sel[i] = 1'b1;
                w_ready  = ~w_pend[i];
            end
        end
    end

    assign w_wr        = w_sel & ~w_pend & {NCH{i_cfg_valid}};
    assign o_cfg_ready = w_ready;
    assign o_pend      = w_pend;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clkdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk     (i_clk),
            .i_clr_n   (i_clr_n),
            .i_en      (i_en[g]),
            .i_wr      (w_wr[g]),
            .i_div     (i_cfg_div),
            .o_tick    (o_tick[g]),
            .o_clk_out (o_clk_out[g]),
            .o_pend    (w_pend[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: a 4-channel default instance plus a narrow
// 3-channel instance for the out-of-range index and full-scale divisor cases.
module tb_clkdiv_multi;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  en;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [24:0] cfg_div;
    logic        cfg_ready;
    logic [3:0]  tick;
    logic [3:0]  clk_out;
    logic [3:0]  pend;

    logic [2:0]  a_en;
    logic        a_valid;
    logic [1:0]  a_ch;
    logic [7:0]  a_div;
    logic        a_ready;
    logic [2:0]  a_tick;
    logic [2:0]  a_clk_out;
    logic [2:0]  a_pend;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected vectors after edges E9..E18 (ch1 on D=5, others on D=2).
    logic [3:0] p2_t [0:9] = '{4'h0, 4'hD, 4'h0, 4'hD, 4'h2, 4'hD, 4'h0, 4'hD, 4'h0, 4'hF};
    logic [3:0] p2_c [0:9] = '{4'h2, 4'hF, 4'h0, 4'hD, 4'h2, 4'hF, 4'h2, 4'hD, 4'h0, 4'hF};
    // Edges E21..E24 (ch2 on D=1).
    logic [3:0] p3_t [0:3] = '{4'h4, 4'hD, 4'h6, 4'hD};
    logic [3:0] p3_c [0:3] = '{4'h4, 4'hD, 4'h6, 4'hF};
    // ch0 on D=4 over E26..E41, en[0] low for E32..E38; bit n is edge E26+n.
    logic [15:0] p4_t = 16'h8011;
    logic [15:0] p4_c = 16'h9FF3;

    always #5 clk = ~clk;

    clkdiv_multi #(.NCH(4)) u_dut (
        .i_clk       (clk),
        .i_clr_n     (clr_n),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_tick      (tick),
        .o_clk_out   (clk_out),
        .o_pend      (pend)
    );

    clkdiv_multi #(.NCH(3), .WIDTH(8)) u_aux (
        .i_clk       (clk),
        .i_clr_n     (clr_n),
        .i_en        (a_en),
        .i_cfg_valid (a_valid),
        .o_cfg_ready (a_ready),
        .i_cfg_ch    (a_ch),
        .i_cfg_div   (a_div),
        .o_tick      (a_tick),
        .o_clk_out   (a_clk_out),
        .o_pend      (a_pend)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int first_k;
        int n_ticks;
        int n_hi;

        clr_n = 1'b0; en = 4'h0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0;
        a_en = 3'h0; a_valid = 1'b0; a_ch = 2'd0; a_div = '0;

        // Reset state.
        step(); step();
        check("rst_tick", tick, 4'h0);
        check("rst_clk",  clk_out, 4'h0);
        check("rst_pend", pend, 4'h0);
        check("rst_rdy",  cfg_ready, 1'b1);

        // Default divide-by-2 on every channel, edges E1..E6.
        clr_n = 1'b1; en = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("p1_tick", tick,    (k % 2 == 0) ? 4'hF : 4'h0);
            check("p1_clk",  clk_out, (k % 2 == 0) ? 4'hF : 4'h0);
        end
        check("p1_pend", pend, 4'h0);

        // ch1 <= 5 on a non-terminal edge (E7); applies at E8.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 25'd5;
        check("p2_rdy_pre", cfg_ready, 1'b1);
        step();
        check("p2_pend_set", pend, 4'h2);
        check("p2_rdy_busy", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        step();
        check("p2_e8_tick", tick, 4'hF);
        check("p2_e8_clk",  clk_out, 4'hF);
        check("p2_e8_pend", pend, 4'h0);
        check("p2_e8_rdy",  cfg_ready, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("p2_tick", tick, p2_t[k]);
            check("p2_clk",  clk_out, p2_c[k]);
        end

        // ch2 <= 0 (acts as 1) at E19, second write held off at E20.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 25'd0;
        step();
        check("p3_e19_tick", tick, 4'h0);
        check("p3_e19_clk",  clk_out, 4'h2);
        check("p3_e19_pend", pend, 4'h4);
        check("p3_e19_rdy",  cfg_ready, 1'b0);
        cfg_div = 25'd7;
        step();
        check("p3_e20_tick", tick, 4'hD);
        check("p3_e20_clk",  clk_out, 4'hF);
        check("p3_stall_pend", pend, 4'h0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("p3_tick", tick, p3_t[k]);
            check("p3_clk",  clk_out, p3_c[k]);
        end

        // ch0 <= 4 at E25, then freeze it for E32..E38.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 25'd4;
        step();
        check("p4_pend_set", pend, 4'h1);
        cfg_valid = 1'b0;
        for (int k = 26; k <= 41; k++) begin
            en = (k >= 32 && k <= 38) ? 4'hE : 4'hF;
            step();
            check("p4_tick0", tick[0], p4_t[k-26]);
            check("p4_clk0",  clk_out[0], p4_c[k-26]);
            if (k == 26) check("p4_pend_clr", pend, 4'h0);
        end
        en = 4'hF;

        // ch3 <= 3 while frozen: applies next edge, cnt and clk_out cleared.
        en = 4'h7; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 25'd3;
        step();
        check("p4b_pend_set", pend, 4'h8);
        check("p4b_hold_clk3", clk_out[3], 1'b0);
        cfg_valid = 1'b0;
        step();
        check("p4b_pend_clr", pend, 4'h0);
        check("p4b_tick3", tick[3], 1'b0);
        check("p4b_clk3",  clk_out[3], 1'b0);
        en = 4'hF;
        step();
        check("p4b_e44_clk3", clk_out[3], 1'b1);
        check("p4b_e44_tick3", tick[3], 1'b0);
        step();
        check("p4b_e45_clk3", clk_out[3], 1'b0);
        step();
        check("p4b_e46_tick3", tick[3], 1'b1);
        check("p4b_e46_clk3",  clk_out[3], 1'b1);

        // ch3 <= 9 pending, then asynchronous reset between edges.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 25'd9;
        step();
        check("p5_pend_set", pend, 4'h8);
        check("p5_clk_pre", clk_out, 4'hC);
        cfg_valid = 1'b0;
        #1 clr_n = 1'b0;
        #1;
        check("p5_async_tick", tick, 4'h0);
        check("p5_async_clk",  clk_out, 4'h0);
        check("p5_async_pend", pend, 4'h0);
        check("p5_async_rdy",  cfg_ready, 1'b1);
        step();
        check("p5_held_clk", clk_out, 4'h0);
        clr_n = 1'b1; en = 4'hF; a_en = 3'h7;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("p5_tick", tick,    (k % 2 == 0) ? 4'hF : 4'h0);
            check("p5_clk",  clk_out, (k % 2 == 0) ? 4'hF : 4'h0);
        end

        // Narrow instance: out-of-range index, then full-scale divisor on ch0.
        a_valid = 1'b1; a_ch = 2'd3; a_div = 8'd9;
        check("a_rdy_oor", a_ready, 1'b1);
        step();
        check("a_pend_oor", a_pend, 3'h0);
        a_valid = 1'b0;
        step();
        check("a_tick_r6", a_tick, 3'h7);
        a_valid = 1'b1; a_ch = 2'd0; a_div = 8'd255;
        step();
        check("a_pend_set", a_pend, 3'h1);
        check("a_rdy_busy", a_ready, 1'b0);
        a_valid = 1'b0;
        step();
        check("a_apply_tick", a_tick[0], 1'b1);
        check("a_apply_pend", a_pend, 3'h0);
        first_k = 0; n_ticks = 0; n_hi = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (a_tick[0]) begin
                n_ticks++;
                if (first_k == 0) first_k = k;
            end
            if (k <= 255 && a_clk_out[0]) n_hi++;
        end
        check("a_max_first", first_k, 255);
        check("a_max_count", n_ticks, 1);
        check("a_max_high",  n_hi, 128);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
